// File: rtl/ipsxe_floating_point_segcr_pkg.sv
// Shared constants for the segment carry-resolve stage: adder split point and
// which pipeline stages exist for each supported latency.
package ipsxe_floating_point_segcr_pkg;

    localparam int LATENCY_MAX = 3;

    // Bit n of each mask says whether that stage is registered when LATENCY == n.
    localparam logic [LATENCY_MAX:0] STG_IN_EN  = 4'b1110;
    localparam logic [LATENCY_MAX:0] STG_MID_EN = 4'b1000;
    localparam logic [LATENCY_MAX:0] STG_OUT_EN = 4'b1100;

    function automatic int split_w(input int hi_w);
        return (hi_w / 2 < 1) ? 1 : hi_w / 2;
    endfunction

endpackage

// File: rtl/ipsxe_floating_point_pipe_reg_v1_0.sv
// Clock-enabled pipeline register with async active-low clear.
// When EN=0 it collapses to a plain wire, so a stage can be dropped by parameter.
module ipsxe_floating_point_pipe_reg_v1_0 #(
    parameter int WIDTH = 1,
    parameter bit EN    = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (EN) begin : g_reg
            logic [WIDTH-1:0] data_d;
            logic [WIDTH-1:0] data_q;

            always_comb begin
                data_d = data_q;
                if (i_ce) data_d = i_d;
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) data_q <= '0;
                else          data_q <= data_d;
            end

            assign o_q = data_q;
        end else begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = ^{i_clk, i_rst_n, i_ce};
            assign o_q         = i_d;
        end
    endgenerate

endmodule

// File: rtl/ipsxe_floating_point_seg_carry_resolve_v1_0.sv
// Resolves a signed carry/borrow word into an unsigned high mantissa segment.
// Optional sign output: define IPSXE_FLOATING_POINT_SEGCR_NEG_FLAG_EN.
module ipsxe_floating_point_seg_carry_resolve_v1_0
    import ipsxe_floating_point_segcr_pkg::*;
#(
    parameter int HI_W    = 9,
    parameter int CIN_W   = 2,
    parameter int LATENCY = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ce,
    input  logic            i_valid,
    input  logic            i_sub,
    input  logic [CIN_W-1:0] i_cin,
    input  logic [HI_W-1:0] i_hi,
    output logic            o_valid,
`ifdef IPSXE_FLOATING_POINT_SEGCR_NEG_FLAG_EN
    output logic            o_neg,
`endif
    output logic [HI_W:0]   o_sum
);

    localparam int SUM_W = HI_W + 1;
`ifdef IPSXE_FLOATING_POINT_SEGCR_NEG_FLAG_EN
    localparam int EXT_W = HI_W + 2;  // one extra bit holds the exact sign
`else
    localparam int EXT_W = HI_W + 1;
`endif
    localparam int LO_W  = split_w(HI_W);
    localparam int UP_W  = EXT_W - LO_W;
    localparam int IN_W  = 2 + CIN_W + HI_W;
    localparam int MID_W = 2 + LO_W + 2 * UP_W;
    localparam int OUT_W = 1 + EXT_W;

    localparam bit LAT_OK = (LATENCY >= 0) && (LATENCY <= LATENCY_MAX);
    localparam bit IN_EN  = LAT_OK ? STG_IN_EN[LATENCY]  : 1'b0;
    localparam bit MID_EN = LAT_OK ? STG_MID_EN[LATENCY] : 1'b0;
    localparam bit OUT_EN = LAT_OK ? STG_OUT_EN[LATENCY] : 1'b0;

    generate
        if (!LAT_OK || CIN_W < 1 || CIN_W > HI_W || HI_W < 2) begin : g_bad_param
            $error("seg_carry_resolve: illegal parameters HI_W=%0d CIN_W=%0d LATENCY=%0d",
                   HI_W, CIN_W, LATENCY);
        end
    endgenerate

    logic [IN_W-1:0]  in_q;
    logic             s1_valid;
    logic             s1_sub;
    logic [CIN_W-1:0] s1_cin;
    logic [HI_W-1:0]  s1_hi;

    ipsxe_floating_point_pipe_reg_v1_0 #(.WIDTH(IN_W), .EN(IN_EN)) u_stg_in (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_ce    (i_ce),
        .i_d     ({i_valid, i_sub, i_cin, i_hi}),
        .o_q     (in_q)
    );

    assign s1_valid = in_q[IN_W-1];
    assign s1_sub   = in_q[IN_W-2];
    assign s1_cin   = in_q[HI_W +: CIN_W];
    assign s1_hi    = in_q[HI_W-1:0];

    // Subtraction is add of ~sext(cin) with a carry-in of one into the low half.
    logic [EXT_W-1:0] op_a;
    logic [EXT_W-1:0] op_b;
    logic [LO_W:0]    lo_sum;

    always_comb begin
        op_a             = '0;
        op_a[HI_W-1:0]   = s1_hi;
        op_b             = {{(EXT_W-CIN_W){s1_cin[CIN_W-1]}}, s1_cin};
        if (s1_sub) op_b = ~op_b;
        lo_sum = {1'b0, op_a[LO_W-1:0]} + {1'b0, op_b[LO_W-1:0]} + {{LO_W{1'b0}}, s1_sub};
    end

    logic [MID_W-1:0] mid_q;
    logic             s2_valid;
    logic             s2_carry;
    logic [LO_W-1:0]  s2_lo;
    logic [UP_W-1:0]  s2_a_up;
    logic [UP_W-1:0]  s2_b_up;
    logic [UP_W-1:0]  up_sum;

    ipsxe_floating_point_pipe_reg_v1_0 #(.WIDTH(MID_W), .EN(MID_EN)) u_stg_mid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_ce    (i_ce),
        .i_d     ({s1_valid, lo_sum, op_a[EXT_W-1:LO_W], op_b[EXT_W-1:LO_W]}),
        .o_q     (mid_q)
    );

    assign s2_valid = mid_q[MID_W-1];
    assign s2_carry = mid_q[MID_W-2];
    assign s2_lo    = mid_q[2*UP_W +: LO_W];
    assign s2_a_up  = mid_q[UP_W +: UP_W];
    assign s2_b_up  = mid_q[UP_W-1:0];
    assign up_sum   = s2_a_up + s2_b_up + {{(UP_W-1){1'b0}}, s2_carry};

    logic [OUT_W-1:0] out_q;

    ipsxe_floating_point_pipe_reg_v1_0 #(.WIDTH(OUT_W), .EN(OUT_EN)) u_stg_out (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_ce    (i_ce),
        .i_d     ({s2_valid, up_sum, s2_lo}),
        .o_q     (out_q)
    );

    assign o_valid = out_q[EXT_W];
    assign o_sum   = out_q[SUM_W-1:0];
`ifdef IPSXE_FLOATING_POINT_SEGCR_NEG_FLAG_EN
    assign o_neg   = out_q[EXT_W-1];
`endif

endmodule

// File: tb/tb_ipsxe_floating_point_seg_carry_resolve_v1_0.sv
// Bench for the segment carry-resolve stage: four 9-bit instances (latency 0..3)
// plus a 24-bit latency-3 instance, all checked against an input-history model.
module tb_ipsxe_floating_point_seg_carry_resolve_v1_0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b1;
    logic        valid = 1'b0;
    logic        sub = 1'b0;
    logic [1:0]  cin = '0;
    logic [8:0]  hi = '0;
    logic [23:0] cin24 = '0;
    logic [23:0] hi24 = '0;

    logic        ov [0:3];
    logic [9:0]  os [0:3];
    logic        ov24;
    logic [24:0] os24;
`ifdef IPSXE_FLOATING_POINT_SEGCR_NEG_FLAG_EN
    logic        on_ [0:3];
    logic        on24;
`endif

    int compared = 0;
    int mismatched = 0;
    bit chk_en = 1'b0;
    bit cnt_en = 1'b0;
    longint got_q[$];
    longint exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ipsxe_floating_point_seg_carry_resolve_v1_0 #(.HI_W(9), .CIN_W(2), .LATENCY(g)) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_ce    (ce),
            .i_valid (valid),
            .i_sub   (sub),
            .i_cin   (cin),
            .i_hi    (hi),
            .o_valid (ov[g]),
`ifdef IPSXE_FLOATING_POINT_SEGCR_NEG_FLAG_EN
            .o_neg   (on_[g]),
`endif
            .o_sum   (os[g])
        );
    end

    ipsxe_floating_point_seg_carry_resolve_v1_0 #(.HI_W(24), .CIN_W(24), .LATENCY(3)) u_dut24 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_ce    (ce),
        .i_valid (valid),
        .i_sub   (sub),
        .i_cin   (cin24),
        .i_hi    (hi24),
        .o_valid (ov24),
`ifdef IPSXE_FLOATING_POINT_SEGCR_NEG_FLAG_EN
        .o_neg   (on24),
`endif
        .o_sum   (os24)
    );

    // Exact signed result of the operation; the DUT reports it modulo 2^(HI_W+1).
    function automatic longint ref_res(input longint h, input longint c, input bit s);
        return s ? h - c : h + c;
    endfunction

    function automatic longint ref_sum(input longint h, input longint c, input bit s, input int w);
        return ref_res(h, c, s) & ((64'sd1 <<< (w + 1)) - 1);
    endfunction

    typedef struct {
        bit     v;
        bit     s;
        longint c9;
        longint h9;
        longint c24;
        longint h24;
    } item_t;

    item_t hist [0:2];

    function automatic item_t cur_item();
        item_t it;
        it.v   = valid;
        it.s   = sub;
        it.c9  = longint'($signed(cin));
        it.h9  = longint'(hi);
        it.c24 = longint'($signed(cin24));
        it.h24 = longint'(hi24);
        return it;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // hist[k] is what was captured k+1 enabled edges ago; reset empties it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0, 0, 0};
        end else if (ce) begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = cur_item();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int l = 0; l < 4; l++) begin
                item_t e;
                e = (l == 0) ? cur_item() : hist[l-1];
                chk($sformatf("lat%0d_valid", l), longint'(ov[l]), longint'(e.v));
                if (e.v) begin
                    chk($sformatf("lat%0d_sum", l), longint'(os[l]), ref_sum(e.h9, e.c9, e.s, 9));
`ifdef IPSXE_FLOATING_POINT_SEGCR_NEG_FLAG_EN
                    chk($sformatf("lat%0d_neg", l), longint'(on_[l]),
                        longint'(ref_res(e.h9, e.c9, e.s) < 0));
`endif
                end
            end
            chk("w24_valid", longint'(ov24), longint'(hist[2].v));
            if (hist[2].v) begin
                chk("w24_sum", longint'(os24), ref_sum(hist[2].h24, hist[2].c24, hist[2].s, 24));
`ifdef IPSXE_FLOATING_POINT_SEGCR_NEG_FLAG_EN
                chk("w24_neg", longint'(on24),
                    longint'(ref_res(hist[2].h24, hist[2].c24, hist[2].s) < 0));
`endif
            end
        end
        if (cnt_en && ov[3] && ce) got_q.push_back(longint'(os[3]));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int idx;
        int cyc;
        int lat_seen;

        for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0, 0, 0};
        repeat (3) step();
        chk_en = 1'b1;
        #1;
        chk("rst_valid1", longint'(ov[1]), 0);
        chk("rst_valid3", longint'(ov[3]), 0);
        chk("rst_sum1", longint'(os[1]), 0);
        chk("rst_sum2", longint'(os[2]), 0);
        chk("rst_sum3", longint'(os[3]), 0);
        rst_n = 1'b1;
        step();

        // Carry into bit HI_W without wrap.
        chk("model_carry", ref_sum(9'h1FF, 1, 0, 9), 64'h200);
        hi = 9'h1FF; cin = 2'b01; sub = 1'b0; valid = 1'b1;
        step();
        chk("lit_carry_valid", longint'(ov[1]), 1);
        chk("lit_carry_sum", longint'(os[1]), 64'h200);

        // Negative carry wraps; subtracting -1 gives +1.
        hi = 9'h000; cin = 2'b11; sub = 1'b0;
        step();
        chk("lit_wrap_sum", longint'(os[1]), 64'h3FF);
`ifdef IPSXE_FLOATING_POINT_SEGCR_NEG_FLAG_EN
        chk("lit_wrap_neg", longint'(on_[1]), 1);
`endif
        sub = 1'b1;
        step();
        chk("lit_sub_sum", longint'(os[1]), 64'h001);

        // Full-width 24-bit add through the split adder.
        sub = 1'b0; hi24 = 24'hFFFFFF; cin24 = 24'h7FFFFF;
        step();
        valid = 1'b0;
        step();
        step();
        chk("lit_w24_valid", longint'(ov24), 1);
        chk("lit_w24_sum", longint'(os24), 64'h17FFFFE);
        repeat (3) step();

        // Eight back-to-back items with a two-cycle stall in the middle.
        cnt_en = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < 8) begin
            ce    = !(cyc == 4 || cyc == 5);
            valid = 1'b1;
            hi    = 9'(idx * 37 + 5);
            cin   = 2'(idx);
            sub   = idx[0];
            if (ce) exp_q.push_back(ref_sum(idx * 37 + 5, longint'($signed(2'(idx))), idx[0], 9));
            step();
            if (ce) idx++;
            cyc++;
        end
        ce = 1'b1;
        valid = 1'b0;
        repeat (6) step();
        cnt_en = 1'b0;
        chk("stall_count", longint'(got_q.size()), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            chk($sformatf("stall_item%0d", i), got_q[i], exp_q[i]);

        // Reset while three items are in flight.
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; hi = 9'(100 + i); cin = 2'b01;
            step();
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_valid3", longint'(ov[3]), 0);
        chk("midrst_sum3", longint'(os[3]), 0);
        valid = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (4) step();
        valid = 1'b1; hi = 9'h0AA; cin = 2'b10; sub = 1'b1;
        lat_seen = 0;
        for (int k = 1; k <= 10 && lat_seen == 0; k++) begin
            step();
            valid = 1'b0;
            if (ov[3]) lat_seen = k;
        end
        chk("post_rst_latency", longint'(lat_seen), 3);

        for (int n = 0; n < 10000; n++) begin
            ce    = ($urandom_range(9) != 0);
            valid = ($urandom_range(4) != 0);
            sub   = 1'($urandom);
            cin   = 2'($urandom);
            hi    = 9'($urandom);
            cin24 = 24'($urandom);
            hi24  = 24'($urandom);
            if ($urandom_range(499) == 0) rst_n = 1'b0;
            step();
            rst_n = 1'b1;
        end
        valid = 1'b0;
        repeat (4) step();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
